// File: rtl/calc_cmd_assembler.sv
// calc_cmd_assembler: assembles UART bytes {A, operator char, B} into one command on a valid/ready handshake.
// Ports: CLK/RST (sync, active-high); RX_VALID/RX_BYTE byte input; CMD_VALID/CMD_READY/CMD_A/CMD_B/CMD_OP command out;
// ERR/ERR_CODE one-cycle error pulse (01 bad op, 10 timeout, 11 overrun); BUSY frame in progress or skid byte held.
module calc_cmd_assembler #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD = 9600,
  parameter int TIMEOUT_CYCLES = (CLK_FREQ / BAUD) * 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_VALID,
  input  logic [7:0] RX_BYTE,
  output logic       CMD_VALID,
  input  logic       CMD_READY,
  output logic [7:0] CMD_A,
  output logic [7:0] CMD_B,
  output logic [1:0] CMD_OP,
  output logic       ERR,
  output logic [1:0] ERR_CODE,
  output logic       BUSY
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GOT_A, GOT_OP, HOLD} state_t;
  state_t state, state_n;
  logic [7:0] a_n, b_n, pend, pend_n;
  logic [1:0] op_n, code_n, op_dec;
  logic pend_full, pend_full_n, err_n, op_ok, expire;
  logic [CW-1:0] cnt, cnt_n;
  assign op_ok = RX_BYTE inside {8'h2B, 8'h2D, 8'h78, 8'h2A, 8'h2F};
  assign op_dec = (RX_BYTE == 8'h2B) ? 2'b00 :
                  (RX_BYTE == 8'h2D) ? 2'b01 :
                  (RX_BYTE == 8'h2F) ? 2'b11 : 2'b10;
  // A byte arriving on the expiry cycle wins, so expiry requires an idle cycle.
  assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1)) && !RX_VALID;
  assign CMD_VALID = (state == HOLD);
  assign BUSY = (state != IDLE) || pend_full;
  always_comb begin
    state_n = state;
    a_n = CMD_A;
    b_n = CMD_B;
    op_n = CMD_OP;
    pend_n = pend;
    pend_full_n = pend_full;
    cnt_n = '0;
    err_n = 1'b0;
    code_n = 2'b00;
    case (state)
      IDLE: begin
        if (RX_VALID) begin
          a_n = RX_BYTE;
          state_n = GOT_A;
        end
      end
      GOT_A: begin
        if (RX_VALID) begin
          op_n = op_ok ? op_dec : CMD_OP;
          state_n = op_ok ? GOT_OP : IDLE;
          err_n = !op_ok;
          code_n = op_ok ? 2'b00 : 2'b01;
        end else if (expire) begin
          err_n = 1'b1;
          code_n = 2'b10;
          state_n = IDLE;
        end else
          cnt_n = cnt + 1'b1;
      end
      GOT_OP: begin
        if (RX_VALID) begin
          b_n = RX_BYTE;
          state_n = HOLD;
        end else if (expire) begin
          err_n = 1'b1;
          code_n = 2'b10;
          state_n = IDLE;
        end else
          cnt_n = cnt + 1'b1;
      end
      HOLD: begin
        // A byte arriving with the skid slot occupied is lost, even on the transfer cycle.
        if (RX_VALID && pend_full) begin
          err_n = 1'b1;
          code_n = 2'b11;
        end
        if (CMD_READY) begin
          state_n = (pend_full || RX_VALID) ? GOT_A : IDLE;
          a_n = pend_full ? pend : RX_VALID ? RX_BYTE : CMD_A;
          pend_full_n = 1'b0;
        end else if (RX_VALID && !pend_full) begin
          pend_n = RX_BYTE;
          pend_full_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      CMD_A <= '0;
      CMD_B <= '0;
      CMD_OP <= '0;
      pend <= '0;
      pend_full <= 1'b0;
      cnt <= '0;
      ERR <= 1'b0;
      ERR_CODE <= 2'b00;
    end else begin
      state <= state_n;
      CMD_A <= a_n;
      CMD_B <= b_n;
      CMD_OP <= op_n;
      pend <= pend_n;
      pend_full <= pend_full_n;
      cnt <= cnt_n;
      ERR <= err_n;
      ERR_CODE <= code_n;
    end
  end
endmodule

// File: tb/tb_calc_cmd_assembler.sv
// tb_calc_cmd_assembler: table, directed and randomized checks of calc_cmd_assembler against a queue-based model.
module tb_calc_cmd_assembler;
  localparam int T = 100;
  logic CLK = 0, RST = 1, RX_VALID = 0, CMD_READY = 0;
  logic [7:0] RX_BYTE = 0;
  logic CMD_VALID, ERR, BUSY;
  logic [7:0] CMD_A, CMD_B;
  logic [1:0] CMD_OP, ERR_CODE;
  calc_cmd_assembler #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .RX_VALID(RX_VALID), .RX_BYTE(RX_BYTE),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_A(CMD_A), .CMD_B(CMD_B),
    .CMD_OP(CMD_OP), .ERR(ERR), .ERR_CODE(ERR_CODE), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  int checks = 0, failures = 0;
  logic [7:0] frame[$], pq[$];
  logic held, m_err;
  logic [7:0] ha, hb;
  logic [1:0] hop, m_code;
  int gap;
  typedef struct {
    logic [7:0] a, op, b;
    logic [1:0] exp_op;
  } vec_t;
  vec_t vecs[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic bit is_op(input logic [7:0] c);
    return c == "+" || c == "-" || c == "x" || c == "*" || c == "/";
  endfunction
  function automatic logic [1:0] op_code(input logic [7:0] c);
    case (c)
      "+": return 2'd0;
      "-": return 2'd1;
      "/": return 2'd3;
      default: return 2'd2;
    endcase
  endfunction
  // Reference: frame bytes collected in a queue, the held command, a one-deep skid queue and an idle-gap count.
  task automatic model_step();
    m_err = 0;
    m_code = 0;
    if (RST) begin
      frame.delete();
      pq.delete();
      held = 0;
      gap = 0;
    end else if (held) begin
      if (RX_VALID && pq.size() != 0) begin
        m_err = 1;
        m_code = 3;
      end
      if (CMD_READY) begin
        held = 0;
        gap = 0;
        if (pq.size() != 0) frame.push_back(pq.pop_front());
        else if (RX_VALID) frame.push_back(RX_BYTE);
      end else if (RX_VALID && pq.size() == 0) pq.push_back(RX_BYTE);
    end else if (RX_VALID) begin
      frame.push_back(RX_BYTE);
      gap = 0;
      if (frame.size() == 2 && !is_op(RX_BYTE)) begin
        m_err = 1;
        m_code = 1;
        frame.delete();
      end else if (frame.size() == 3) begin
        held = 1;
        ha = frame[0];
        hop = op_code(frame[1]);
        hb = frame[2];
        frame.delete();
      end
    end else if (frame.size() != 0) begin
      gap++;
      if (gap == T) begin
        m_err = 1;
        m_code = 2;
        frame.delete();
        gap = 0;
      end
    end
  endtask
  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    chk("m_valid", CMD_VALID, held);
    if (held) begin
      chk("m_a", CMD_A, ha);
      chk("m_b", CMD_B, hb);
      chk("m_op", CMD_OP, hop);
    end
    chk("m_err", ERR, m_err);
    chk("m_code", ERR_CODE, m_code);
    chk("m_busy", BUSY, held || frame.size() != 0 || pq.size() != 0);
  endtask
  task automatic idle(input int n);
    RX_VALID = 0;
    repeat (n) cycle();
  endtask
  task automatic send(input logic [7:0] b);
    RX_VALID = 1;
    RX_BYTE = b;
    cycle();
    RX_VALID = 0;
  endtask
  task automatic frame3(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
    send(a);
    idle(2);
    send(op);
    idle(2);
    send(b);
  endtask
  task automatic cmd_is(input string name, input logic [7:0] a, input logic [1:0] op, input logic [7:0] b);
    chk({name, "_valid"}, CMD_VALID, 1);
    chk({name, "_a"}, CMD_A, a);
    chk({name, "_op"}, CMD_OP, op);
    chk({name, "_b"}, CMD_B, b);
  endtask
  task automatic take();
    CMD_READY = 1;
    cycle();
    CMD_READY = 0;
  endtask
  initial begin
    logic [7:0] ops[5];
    ops = '{8'h2B, 8'h2D, 8'h78, 8'h2A, 8'h2F};
    vecs = '{'{8'd5, "+", 8'd10, 2'd0}, '{8'd30, "-", 8'd20, 2'd1}, '{8'd15, "x", 8'd10, 2'd2},
             '{8'd15, "*", 8'd10, 2'd2}, '{8'd50, "/", 8'd5, 2'd3}, '{8'd15, "/", 8'd0, 2'd3}};
    idle(2);
    chk("rst_valid", CMD_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_a", CMD_A, 0);
    RST = 0;
    idle(2);
    foreach (vecs[i]) begin
      frame3(vecs[i].a, vecs[i].op, vecs[i].b);
      cmd_is("tbl", vecs[i].a, vecs[i].exp_op, vecs[i].b);
      chk("tbl_err", ERR, 0);
      take();
      chk("tbl_drop", CMD_VALID, 0);
      chk("tbl_busy", BUSY, 0);
      idle(3);
    end
    send(7);
    send("%");
    chk("badop_err", ERR, 1);
    chk("badop_code", ERR_CODE, 1);
    chk("badop_busy", BUSY, 0);
    idle(1);
    chk("badop_pulse", ERR, 0);
    frame3(1, "+", 2);
    cmd_is("after_bad", 1, 0, 2);
    take();
    send(9);
    idle(T - 1);
    chk("to_early_err", ERR, 0);
    chk("to_early_busy", BUSY, 1);
    idle(1);
    chk("to_err", ERR, 1);
    chk("to_code", ERR_CODE, 2);
    chk("to_busy", BUSY, 0);
    idle(2);
    send(9);
    idle(T - 2);
    send("+");
    chk("to99_err", ERR, 0);
    idle(T - 1);
    send(4);
    chk("to_edge_err", ERR, 0);
    cmd_is("to_edge", 9, 0, 4);
    take();
    frame3(5, "+", 10);
    idle(3);
    send(30);
    cmd_is("skid_hold", 5, 0, 10);
    send("-");
    chk("ovr_err", ERR, 1);
    chk("ovr_code", ERR_CODE, 3);
    cmd_is("ovr_hold", 5, 0, 10);
    take();
    chk("skid_valid", CMD_VALID, 0);
    chk("skid_busy", BUSY, 1);
    send("-");
    send(20);
    cmd_is("skid_cmd", 30, 1, 20);
    CMD_READY = 1;
    send(77);
    CMD_READY = 0;
    chk("hsrx_busy", BUSY, 1);
    chk("hsrx_err", ERR, 0);
    send("*");
    send(3);
    cmd_is("hsrx_cmd", 77, 2, 3);
    send(1);
    CMD_READY = 1;
    send(2);
    CMD_READY = 0;
    chk("hsovr_code", ERR_CODE, 3);
    send("/");
    send(0);
    cmd_is("hsovr_cmd", 1, 3, 0);
    take();
    send(5);
    send("+");
    RST = 1;
    idle(1);
    RST = 0;
    chk("mrst_busy", BUSY, 0);
    chk("mrst_a", CMD_A, 0);
    chk("mrst_op", CMD_OP, 0);
    chk("mrst_valid", CMD_VALID, 0);
    send(8);
    send("-");
    send(3);
    cmd_is("mrst_cmd", 8, 1, 3);
    take();
    for (int k = 0; k < 4000; k++) begin
      RST = ($urandom_range(0, 599) == 0);
      CMD_READY = $urandom_range(0, 1);
      RX_VALID = ($urandom_range(0, 3) == 0);
      RX_BYTE = ($urandom_range(0, 2) == 0) ? 8'($urandom) : ops[$urandom_range(0, 4)];
      cycle();
      if ($urandom_range(0, 199) == 0) begin
        RST = 0;
        idle($urandom_range(T - 3, T + 3));
      end
    end
    RST = 0;
    RX_VALID = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
